// File: rtl/mem_responder.sv
// Memory-side responder: four-phase read/wren handshake in front of a word-addressed RAM,
// with a programmable number of wait states between request capture and the array access.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int              IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              WAIT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]      WAIT_INIT   = WAIT_INIT_I[3:0];
  localparam logic [ADDR_W:0] DEPTH_LIM   = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              rd_reg, rd_next;
  logic              wr_reg, wr_next;
  logic              ready_reg, ready_next;
  logic              busy_reg, busy_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] dout_reg;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [IDX_W-1:0]  ram_idx;
  logic              bad;
  logic              ram_we;
  logic              ram_re;
  logic              clr_dout;

  // Out-of-range addresses are rejected, never aliased onto the array.
  assign bad     = (rd_reg & wr_reg) | ({1'b0, addr_reg} >= DEPTH_LIM);
  assign ram_idx = addr_reg[IDX_W-1:0];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    rd_next    = rd_reg;
    wr_next    = wr_reg;
    ready_next = ready_reg;
    busy_next  = busy_reg;
    err_next   = err_reg;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    clr_dout   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (read | wren) begin
          addr_next  = addr;
          data_next  = data_in;
          rd_next    = read;
          wr_next    = wren;
          busy_next  = 1'b1;
          cnt_next   = WAIT_INIT;
          state_next = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) state_next = S_ACCESS;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      S_ACCESS: begin
        ready_next = 1'b1;
        busy_next  = 1'b0;
        err_next   = bad;
        state_next = S_HOLD;
        if (bad)         clr_dout = 1'b1;
        else if (wr_reg) ram_we   = 1'b1;
        else             ram_re   = 1'b1;
      end
      S_HOLD: begin
        // Only a fully dropped request releases the handshake; a type switch does not.
        if (!(read | wren)) begin
          ready_next = 1'b0;
          err_next   = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= '0;
      data_reg  <= '0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      rd_reg    <= rd_next;
      wr_reg    <= wr_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
      err_reg   <= err_next;
    end
  end

  // Array write is gated by reset so an interrupted write leaves memory untouched.
  always_ff @(posedge clk) begin
    if (ram_we && reset) ram[ram_idx] <= data_reg;
  end

  always_ff @(posedge clk) begin
    if (!reset)        dout_reg <= '0;
    else if (ram_re)   dout_reg <= ram[ram_idx];
    else if (clr_dout) dout_reg <= '0;
  end

  assign data_out = dout_reg;
  assign ready    = ready_reg;
  assign busy     = busy_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (default, zero wait states, 256-word depth)
// driven by a table, hand-written handshake sequences and random accesses against a model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_v  [3];
  logic        wren_v  [3];
  logic [8:0]  addr_v  [3];
  logic [31:0] din_v   [3];
  logic [31:0] dout_v  [3];
  logic        ready_v [3];
  logic        busy_v  [3];
  logic        err_v   [3];

  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES(2)) dut0 (
    .clk(clk), .reset(reset), .read(read_v[0]), .wren(wren_v[0]), .addr(addr_v[0]),
    .data_in(din_v[0]), .data_out(dout_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .err(err_v[0]));
  mem_responder #(.WAIT_STATES(0)) dut1 (
    .clk(clk), .reset(reset), .read(read_v[1]), .wren(wren_v[1]), .addr(addr_v[1]),
    .data_in(din_v[1]), .data_out(dout_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .err(err_v[1]));
  mem_responder #(.DEPTH(256)) dut2 (
    .clk(clk), .reset(reset), .read(read_v[2]), .wren(wren_v[2]), .addr(addr_v[2]),
    .data_in(din_v[2]), .data_out(dout_v[2]), .ready(ready_v[2]), .busy(busy_v[2]), .err(err_v[2]));

  int ws_p    [3] = '{2, 0, 2};
  int depth_p [3] = '{512, 512, 256};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain memory image per instance plus the last data_out value.
  logic [31:0] mem_m   [3][512];
  bit          known_m [3][512];
  logic [31:0] dout_m  [3];

  typedef struct {
    int          k;
    bit          rd;
    bit          wr;
    logic [8:0]  a;
    logic [31:0] d;
    bit          e_err;
    logic [31:0] e_dout;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_apply(input int k, input bit rd, input bit wr, input logic [8:0] a,
                             input logic [31:0] d, output bit e_err, output logic [31:0] e_dout);
    if ((rd && wr) || (int'(a) >= depth_p[k])) begin
      e_err     = 1'b1;
      dout_m[k] = '0;
    end else if (wr) begin
      e_err         = 1'b0;
      mem_m[k][a]   = d;
      known_m[k][a] = 1'b1;
    end else begin
      e_err     = 1'b0;
      dout_m[k] = mem_m[k][a];
    end
    e_dout = dout_m[k];
  endtask

  // One full handshake: raise request, wait for ready, hold, drop, confirm release.
  task automatic do_access(input int k, input bit rd, input bit wr, input logic [8:0] a,
                           input logic [31:0] d, input int hold,
                           output logic [31:0] g_dout, output logic g_err);
    int n;
    int busy_n;
    logic [31:0] held;
    @(negedge clk);
    read_v[k] = rd; wren_v[k] = wr; addr_v[k] = a; din_v[k] = d;
    busy_n = 0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ready_v[k]) break;
      if (busy_v[k]) busy_n++;
    end
    g_dout = dout_v[k];
    g_err  = err_v[k];
    if (!ready_v[k]) begin
      check("ready_timeout", 32'(ready_v[k]), 32'd1);
      read_v[k] = 1'b0; wren_v[k] = 1'b0;
      return;
    end
    check("latency", 32'(n - 1), 32'(ws_p[k] + 1));
    check("busy_cycles", 32'(busy_n), 32'(ws_p[k] + 1));
    check("busy_at_ready", 32'(busy_v[k]), 32'd0);
    held = g_dout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ready", 32'(ready_v[k]), 32'd1);
      check("hold_busy", 32'(busy_v[k]), 32'd0);
      check("hold_err", 32'(err_v[k]), 32'(g_err));
      check("hold_dout", dout_v[k], held);
    end
    read_v[k] = 1'b0; wren_v[k] = 1'b0;
    @(negedge clk);
    check("drop_ready", 32'(ready_v[k]), 32'd0);
    check("drop_err", 32'(err_v[k]), 32'd0);
    check("drop_dout", dout_v[k], held);
    $display("txn k=%0d rd=%0d wr=%0d addr=0x%03h din=0x%08h -> dout=0x%08h err=%0d lat=%0d",
             k, rd, wr, a, d, g_dout, g_err, n - 1);
  endtask

  initial begin
    logic [31:0] gd;
    logic        ge;
    logic [31:0] md;
    bit          me;
    int          n;
    bit          rd, wr;
    logic [8:0]  a;

    tbl[0]  = '{0, 1'b0, 1'b1, 9'h005, 32'h0000_1234, 1'b0, 32'h0000_0000};
    tbl[1]  = '{0, 1'b1, 1'b0, 9'h005, 32'h0000_0000, 1'b0, 32'h0000_1234};
    tbl[2]  = '{0, 1'b1, 1'b1, 9'h005, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
    tbl[3]  = '{0, 1'b1, 1'b0, 9'h005, 32'h0000_0000, 1'b0, 32'h0000_1234};
    tbl[4]  = '{0, 1'b0, 1'b1, 9'h010, 32'h1111_0000, 1'b0, 32'h0000_1234};
    tbl[5]  = '{1, 1'b0, 1'b1, 9'h1FF, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000};
    tbl[6]  = '{1, 1'b1, 1'b0, 9'h1FF, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5};
    tbl[7]  = '{2, 1'b0, 1'b1, 9'h100, 32'h0000_0055, 1'b1, 32'h0000_0000};
    tbl[8]  = '{2, 1'b1, 1'b0, 9'h100, 32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[9]  = '{2, 1'b0, 1'b1, 9'h0FF, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
    tbl[10] = '{2, 1'b1, 1'b0, 9'h0FF, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    tbl[11] = '{2, 1'b1, 1'b0, 9'h100, 32'h0000_0000, 1'b1, 32'h0000_0000};

    for (int k = 0; k < 3; k++) begin
      read_v[k] = 1'b0; wren_v[k] = 1'b0; addr_v[k] = '0; din_v[k] = '0;
      dout_m[k] = '0;
      for (int i = 0; i < 512; i++) begin
        known_m[k][i] = 1'b0;
        mem_m[k][i]   = '0;
      end
    end

    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_ready", 32'(ready_v[k]), 32'd0);
      check("reset_busy", 32'(busy_v[k]), 32'd0);
      check("reset_err", 32'(err_v[k]), 32'd0);
      check("reset_dout", dout_v[k], 32'd0);
    end
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_access(tbl[i].k, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, 1, gd, ge);
      model_apply(tbl[i].k, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, me, md);
      check("tbl_err", 32'(ge), 32'(tbl[i].e_err));
      check("tbl_dout", gd, tbl[i].e_dout);
    end

    // Reset during WAIT abandons the pending write.
    @(negedge clk);
    wren_v[0] = 1'b1; addr_v[0] = 9'h010; din_v[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy_v[0]), 32'd1);
    reset = 1'b0; wren_v[0] = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(ready_v[0]), 32'd0);
    check("rst_mid_busyoff", 32'(busy_v[0]), 32'd0);
    check("rst_mid_err", 32'(err_v[0]), 32'd0);
    check("rst_mid_dout", dout_v[0], 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) dout_m[k] = '0;
    do_access(0, 1'b1, 1'b0, 9'h010, 32'd0, 0, gd, ge);
    model_apply(0, 1'b1, 1'b0, 9'h010, 32'd0, me, md);
    check("rst_read_dout", gd, 32'h1111_0000);
    check("rst_read_err", 32'(ge), 32'd0);

    // Request held for five cycles after ready: ready stays up, no second access.
    do_access(0, 1'b1, 1'b0, 9'h005, 32'd0, 5, gd, ge);
    model_apply(0, 1'b1, 1'b0, 9'h005, 32'd0, me, md);
    check("hold5_dout", gd, 32'h0000_1234);

    // Request dropped one cycle after capture: ready is a single-cycle pulse.
    @(negedge clk);
    read_v[0] = 1'b1; addr_v[0] = 9'h005;
    @(negedge clk);
    read_v[0] = 1'b0;
    check("early_busy", 32'(busy_v[0]), 32'd1);
    for (n = 0; n < 20; n++) begin
      if (ready_v[0]) break;
      @(negedge clk);
    end
    check("early_ready", 32'(ready_v[0]), 32'd1);
    check("early_dout", dout_v[0], 32'h0000_1234);
    @(negedge clk);
    check("early_pulse", 32'(ready_v[0]), 32'd0);
    model_apply(0, 1'b1, 1'b0, 9'h005, 32'd0, me, md);

    // Switching read to wren without a low cycle must not start a new access.
    do_access(0, 1'b0, 1'b1, 9'h006, 32'h0000_0600, 0, gd, ge);
    model_apply(0, 1'b0, 1'b1, 9'h006, 32'h0000_0600, me, md);
    @(negedge clk);
    read_v[0] = 1'b1; addr_v[0] = 9'h006;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ready_v[0]) break;
    end
    check("sw_ready", 32'(ready_v[0]), 32'd1);
    check("sw_dout", dout_v[0], 32'h0000_0600);
    model_apply(0, 1'b1, 1'b0, 9'h006, 32'd0, me, md);
    read_v[0] = 1'b0; wren_v[0] = 1'b1; din_v[0] = 32'h0000_0077;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sw_hold_ready", 32'(ready_v[0]), 32'd1);
      check("sw_hold_busy", 32'(busy_v[0]), 32'd0);
    end
    wren_v[0] = 1'b0;
    @(negedge clk);
    check("sw_release", 32'(ready_v[0]), 32'd0);
    do_access(0, 1'b1, 1'b0, 9'h006, 32'd0, 0, gd, ge);
    model_apply(0, 1'b1, 1'b0, 9'h006, 32'd0, me, md);
    check("sw_nowrite", gd, 32'h0000_0600);

    // Random accesses against the model.
    for (int k = 0; k < 3; k++) begin
      for (int it = 0; it < 25; it++) begin
        n  = int'($urandom_range(0, 9));
        wr = (n < 4) || (n >= 8);
        rd = (n >= 4);
        if (k == 2 && $urandom_range(0, 3) == 0) a = 9'(256 + $urandom_range(0, 255));
        else if ($urandom_range(0, 7) == 0)      a = 9'h1FF;
        else                                     a = 9'($urandom_range(0, 15));
        if (rd && !wr && int'(a) < depth_p[k] && !known_m[k][a]) begin
          rd = 1'b0; wr = 1'b1;
        end
        do_access(k, rd, wr, a, $urandom, int'($urandom_range(0, 2)), gd, ge);
        model_apply(k, rd, wr, a, din_v[k], me, md);
        check("rnd_err", 32'(ge), 32'(me));
        check("rnd_dout", gd, md);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
